// File: rtl/cache_arb_pkg.sv
// Shared types for the I/D cache to memory arbiter.
// Holds the FSM state encoding, the requester identity and the bus widths.
package cache_arb_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned LineWidth = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_e;

  // Round-robin tie break: favour whoever did not win last time.
  function automatic requester_e rr_pick(input requester_e last);
    return (last == REQ_I) ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Two-requester (I-cache fill, D-cache fill/write-back) arbiter onto one memory port.
// Round-robin on ties; a forced IDLE cycle separates every pair of grants.
module cache_arbiter
  import cache_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 i_pmem_read,
  input  logic [AddrWidth-1:0] i_pmem_address,
  output logic [LineWidth-1:0] i_pmem_rdata,
  output logic                 i_pmem_resp,

  input  logic                 d_pmem_read,
  input  logic                 d_pmem_write,
  input  logic [AddrWidth-1:0] d_pmem_address,
  input  logic [LineWidth-1:0] d_pmem_wdata,
  output logic [LineWidth-1:0] d_pmem_rdata,
  output logic                 d_pmem_resp,

  output logic                 mem_read,
  output logic                 mem_write,
  output logic [AddrWidth-1:0] mem_address,
  output logic [LineWidth-1:0] mem_wdata,
  input  logic [LineWidth-1:0] mem_rdata,
  input  logic                 mem_resp
);

  arb_state_e state_q, state_d;
  requester_e last_grant_q, last_grant_d;

  logic i_pending;
  logic d_pending;

  assign i_pending = i_pmem_read;
  assign d_pending = d_pmem_read | d_pmem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;

    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_address  = '0;
    mem_wdata    = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    // Read data is a straight fan-out; only the resp strobes qualify it.
    i_pmem_rdata = mem_rdata;
    d_pmem_rdata = mem_rdata;

    case (state_q)
      IDLE: begin
        if (i_pending && d_pending) begin
          last_grant_d = rr_pick(last_grant_q);
          state_d      = (rr_pick(last_grant_q) == REQ_D) ? GRANT_D : GRANT_I;
        end else if (i_pending) begin
          last_grant_d = REQ_I;
          state_d      = GRANT_I;
        end else if (d_pending) begin
          last_grant_d = REQ_D;
          state_d      = GRANT_D;
        end
      end

      GRANT_I: begin
        mem_read    = 1'b1;
        mem_address = i_pmem_address;
        i_pmem_resp = mem_resp;
        if (mem_resp) begin
          state_d = IDLE;
        end
      end

      GRANT_D: begin
        // A simultaneous read+write is treated as the write-back only.
        mem_write   = d_pmem_write;
        mem_read    = d_pmem_read & ~d_pmem_write;
        mem_address = d_pmem_address;
        mem_wdata   = d_pmem_wdata;
        d_pmem_resp = mem_resp;
        if (mem_resp) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: directed requesters push expected grants,
// a negedge monitor pops and checks them as the memory port shows them.
module tb_cache_arbiter;

  typedef struct packed {
    bit           is_d;
    bit           wr;
    bit           abort;
    logic [31:0]  addr;
    logic [255:0] wdata;
    int           lat;
  } exp_t;

  typedef struct packed {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } d_job_t;

  logic         clk;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  cache_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   compared   = 0;
  int   mismatched = 0;
  int   lat        = 5;
  exp_t exp_q[$];

  function automatic logic [255:0] line_of(input logic [31:0] addr);
    return {8{addr ^ 32'hC0DE_0000}};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic expect_grant(input bit is_d, input bit wr, input logic [31:0] addr,
                              input logic [255:0] wdata, input int l, input bit abort);
    exp_t e;
    e.is_d  = is_d;
    e.wr    = wr;
    e.abort = abort;
    e.addr  = addr;
    e.wdata = wdata;
    e.lat   = l;
    exp_q.push_back(e);
  endtask

  // Memory model: resp on the lat-th cycle of a command, updated just after each edge.
  initial begin
    int cnt;
    cnt       = 0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_read === 1'b1 || mem_write === 1'b1) begin
        cnt++;
        if (cnt == lat) begin
          mem_resp  = 1'b1;
          mem_rdata = line_of(mem_address);
        end else begin
          mem_resp  = 1'b0;
          mem_rdata = '0;
        end
      end else begin
        cnt       = 0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
      end
    end
  end

  // Monitor
  bit           in_grant  = 1'b0;
  bit           prev_resp = 1'b0;
  exp_t         cur;
  int           cyc;
  logic [33:0]  snap_cmd;
  logic [255:0] snap_wd;

  initial begin
    bit cmd;
    bit rsp;
    forever begin
      @(negedge clk);
      cmd = (mem_read === 1'b1) || (mem_write === 1'b1);
      rsp = (i_pmem_resp === 1'b1) || (d_pmem_resp === 1'b1);
      if (prev_resp) begin
        check("idle_gap", 256'(cmd), 256'(0));
        prev_resp = 1'b0;
      end
      if (in_grant && !cmd) begin
        check("drop_without_resp", 256'(cur.abort), 256'(1));
        in_grant = 1'b0;
      end else if (in_grant) begin
        cyc++;
        check("cmd_stable", 256'({mem_read, mem_write, mem_address}), 256'(snap_cmd));
        check("wdata_stable", mem_wdata, snap_wd);
      end else if (cmd) begin
        in_grant = 1'b1;
        cyc      = 1;
        snap_cmd = {mem_read, mem_write, mem_address};
        snap_wd  = mem_wdata;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_grant: got addr %h with no grant pending", mem_address);
          cur       = '0;
          cur.abort = 1'b1;
        end else begin
          cur = exp_q.pop_front();
          check("grant_addr", 256'(mem_address), 256'(cur.addr));
          check("grant_op", 256'({mem_read, mem_write}), 256'(cur.wr ? 2'b01 : 2'b10));
          if (cur.wr) check("grant_wdata", mem_wdata, cur.wdata);
        end
      end
      if (rsp) begin
        check("resp_owner", 256'({i_pmem_resp, d_pmem_resp}), 256'(cur.is_d ? 2'b01 : 2'b10));
        if (!in_grant) begin
          check("resp_in_grant", 256'(in_grant), 256'(1));
        end else begin
          check("resp_on_aborted", 256'(cur.abort), 256'(0));
          check("resp_cycle", 256'(cyc), 256'(cur.lat));
          check("resp_rdata", cur.is_d ? d_pmem_rdata : i_pmem_rdata, line_of(cur.addr));
        end
        in_grant  = 1'b0;
        prev_resp = 1'b1;
      end
    end
  end

  // I requester: holds each request until resp, then moves straight to the next one.
  task automatic run_i(input logic [31:0] addrs[$]);
    foreach (addrs[k]) begin
      bit got;
      got            = 1'b0;
      i_pmem_read    = 1'b1;
      i_pmem_address = addrs[k];
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk);
        if (i_pmem_resp === 1'b1) got = 1'b1;
      end
      if (!got) check("i_resp_timeout", 256'(got), 256'(1));
      @(posedge clk);
      #2;
      i_pmem_read = 1'b0;
    end
  endtask

  task automatic run_d(input d_job_t jobs[$]);
    foreach (jobs[k]) begin
      bit got;
      got            = 1'b0;
      d_pmem_read    = jobs[k].rd;
      d_pmem_write   = jobs[k].wr;
      d_pmem_address = jobs[k].addr;
      d_pmem_wdata   = jobs[k].wdata;
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk);
        if (d_pmem_resp === 1'b1) got = 1'b1;
      end
      if (!got) check("d_resp_timeout", 256'(got), 256'(1));
      @(posedge clk);
      #2;
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  function automatic d_job_t mk_d(input logic rd, input logic wr, input logic [31:0] addr,
                                  input logic [255:0] wdata);
    d_job_t j;
    j.rd    = rd;
    j.wr    = wr;
    j.addr  = addr;
    j.wdata = wdata;
    return j;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0]  ia[$];
    d_job_t       dj[$];
    logic [255:0] pat_a5;
    logic [255:0] pat_3c;
    pat_a5 = {32{8'hA5}};
    pat_3c = {32{8'h3C}};

    rst            = 1'b1;
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("reset_mem_cmd", 256'({mem_read, mem_write}), 256'(0));
    check("reset_resp", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));

    // Lone I read, 5-cycle memory.
    lat = 5;
    expect_grant(1'b0, 1'b0, 32'h0000_1000, '0, 5, 1'b0);
    @(posedge clk);
    #2;
    ia = '{32'h0000_1000};
    run_i(ia);
    repeat (3) @(posedge clk);
    check("lone_i_drained", 256'(exp_q.size()), 256'(0));

    // Simultaneous I and D reads straight after reset: D wins the first tie.
    do_reset();
    lat = 3;
    expect_grant(1'b1, 1'b0, 32'h0000_3000, '0, 3, 1'b0);
    expect_grant(1'b0, 1'b0, 32'h0000_1040, '0, 3, 1'b0);
    ia = '{32'h0000_1040};
    dj = '{mk_d(1'b1, 1'b0, 32'h0000_3000, '0)};
    fork
      run_i(ia);
      run_d(dj);
    join
    repeat (3) @(posedge clk);
    check("tie_drained", 256'(exp_q.size()), 256'(0));

    // D write-back, then D fill with I waiting: I slots in between.
    lat = 4;
    expect_grant(1'b1, 1'b1, 32'h0000_2000, pat_a5, 4, 1'b0);
    expect_grant(1'b0, 1'b0, 32'h0000_1080, '0, 4, 1'b0);
    expect_grant(1'b1, 1'b0, 32'h0000_2040, '0, 4, 1'b0);
    ia = '{32'h0000_1080};
    dj = '{mk_d(1'b0, 1'b1, 32'h0000_2000, pat_a5), mk_d(1'b1, 1'b0, 32'h0000_2040, '0)};
    fork
      run_i(ia);
      run_d(dj);
    join
    repeat (3) @(posedge clk);
    check("wb_fill_drained", 256'(exp_q.size()), 256'(0));

    // Read and write together: write wins; single-cycle memory.
    lat = 1;
    expect_grant(1'b1, 1'b1, 32'h0000_4000, pat_3c, 1, 1'b0);
    dj = '{mk_d(1'b1, 1'b1, 32'h0000_4000, pat_3c)};
    run_d(dj);
    repeat (3) @(posedge clk);
    check("rdwr_drained", 256'(exp_q.size()), 256'(0));

    // Reset on the 3rd cycle of an I grant abandons it.
    do_reset();
    lat = 10;
    expect_grant(1'b0, 1'b0, 32'h0000_1100, '0, 10, 1'b1);
    @(posedge clk);
    #2;
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_1100;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (mem_read === 1'b1) seen = 1'b1;
      end
      check("abort_grant_seen", 256'(seen), 256'(1));
    end
    repeat (2) @(posedge clk);
    #2;
    rst         = 1'b1;
    i_pmem_read = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("abort_mem_read", 256'(mem_read), 256'(0));
    check("abort_i_resp", 256'(i_pmem_resp), 256'(0));
    repeat (3) @(posedge clk);
    check("abort_drained", 256'(exp_q.size()), 256'(0));

    // Continuous traffic: strict D/I alternation, starting with D after reset.
    lat = 2;
    ia = {};
    dj = {};
    for (int k = 0; k < 10; k++) begin
      logic [31:0] da;
      logic [31:0] iaddr;
      da    = 32'h0000_5000 + 32'(k * 32);
      iaddr = 32'h0000_1200 + 32'(k * 32);
      if (k % 2 == 0) begin
        dj.push_back(mk_d(1'b0, 1'b1, da, {32{8'(k + 1)}}));
        expect_grant(1'b1, 1'b1, da, {32{8'(k + 1)}}, 2, 1'b0);
      end else begin
        dj.push_back(mk_d(1'b1, 1'b0, da, '0));
        expect_grant(1'b1, 1'b0, da, '0, 2, 1'b0);
      end
      ia.push_back(iaddr);
      expect_grant(1'b0, 1'b0, iaddr, '0, 2, 1'b0);
    end
    @(posedge clk);
    #2;
    fork
      run_i(ia);
      run_d(dj);
    join
    repeat (5) @(posedge clk);
    check("stream_drained", 256'(exp_q.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
